// File: rtl/hash_move_ctrl_if.sv
// Signal bundle between the tic-tac-toe move controller and its surroundings
// (buttons in, game core feedback in, move presentation out).
interface hash_move_ctrl_if;
    logic       btn_next;
    logic       btn_confirm;
    logic [8:0] occupied;
    logic       game_over;
    logic [3:0] position;
    logic       player;
    logic [3:0] cursor;
    logic       invalid;
    logic       busy;

    modport master (
        input  btn_next, btn_confirm, occupied, game_over,
        output position, player, cursor, invalid, busy
    );

    modport slave (
        output btn_next, btn_confirm, occupied, game_over,
        input  position, player, cursor, invalid, busy
    );
endinterface

// File: rtl/hash_move_ctrl.sv
// Tic-tac-toe input stage: debounces two buttons, steers a cursor over free
// cells and presents each move to the game core as a one-cycle position strobe.
module hash_move_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         ACK_TIMEOUT     = 8,
    parameter logic [3:0] IDLE_POS        = 4'hF
) (
    input logic              clk,
    input logic              reset,
    hash_move_ctrl_if.master bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int AW   = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {S_SELECT, S_COMMIT, S_WAIT_ACK, S_LOCKED} state_e;

    // Bit 0 = next button, bit 1 = confirm button.
    logic [1:0]      raw_btn;
    logic [1:0]      sync1_q, sync2_q, level_q, press_q;
    logic [DB_W-1:0] db_cnt_q [2];

    assign raw_btn = {bus.btn_confirm, bus.btn_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so each flop samples the pre-edge value of the one before it.
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q[i]  <= sync2_q[i];
                    press_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // First free cell after cur (wrapping 8->0); cur itself if none is free.
    function automatic logic [3:0] next_free(input logic [3:0] cur, input logic [8:0] occ);
        logic [3:0] idx;
        logic       found;
        next_free = cur;
        found     = 1'b0;
        idx       = cur;
        for (int k = 1; k < 9; k++) begin
            idx = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
            if (!found && !occ[idx]) begin
                next_free = idx;
                found     = 1'b1;
            end
        end
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    cursor_q, cursor_d;
    logic          player_q, player_d;
    logic          invalid_q, invalid_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_SELECT;
            cursor_q  <= '0;
            player_q  <= 1'b0;
            invalid_q <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            player_q  <= player_d;
            invalid_q <= invalid_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        cursor_d  = cursor_q;
        player_d  = player_q;
        invalid_d = 1'b0;
        ack_cnt_d = ack_cnt_q;
        if (bus.game_over) begin
            state_d = S_LOCKED;
        end else begin
            unique case (state_q)
                S_SELECT: begin
                    ack_cnt_d = '0;
                    if (press_q[1]) begin
                        if (bus.occupied[cursor_q]) invalid_d = ~invalid_q;
                        else                        state_d   = S_COMMIT;
                    end else if (press_q[0]) begin
                        cursor_d = next_free(cursor_q, bus.occupied);
                    end
                end
                // The commit cycle counts toward the acknowledge window.
                S_COMMIT: begin
                    ack_cnt_d = AW'(1);
                    state_d   = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.occupied[cursor_q]) begin
                        player_d = ~player_q;
                        state_d  = S_SELECT;
                    end else if (ack_cnt_q >= AW'(ACK_TIMEOUT - 1)) begin
                        invalid_d = ~invalid_q;
                        state_d   = S_SELECT;
                    end else begin
                        ack_cnt_d = ack_cnt_q + AW'(1);
                    end
                end
                S_LOCKED: state_d = S_LOCKED;
                default:  state_d = S_SELECT;
            endcase
        end
    end

    assign bus.position = (state_q == S_COMMIT) ? cursor_q : IDLE_POS;
    assign bus.player   = player_q;
    assign bus.cursor   = cursor_q;
    assign bus.invalid  = invalid_q;
    assign bus.busy     = (state_q == S_COMMIT) || (state_q == S_WAIT_ACK);
endmodule

// File: tb/tb_hash_move_ctrl.sv
// Directed bench for hash_move_ctrl: buttons, cursor search, commit/ack,
// timeout, lock-out, and a short game against a behavioural board model.
module tb_hash_move_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hash_move_ctrl_if bus();

    hash_move_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next();
        bus.btn_next = 1'b1;
        tick(10);
        bus.btn_next = 1'b0;
        tick(10);
    endtask

    task automatic wait_strobe(input int max, output bit found, output logic [3:0] pos,
                               output logic pl);
        found = 1'b0;
        pos   = 4'hF;
        pl    = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (bus.position !== 4'hF) begin
                found = 1'b1;
                pos   = bus.position;
                pl    = bus.player;
            end
        end
    endtask

    task automatic watch(input int n, output int strobes, output int invs);
        strobes = 0;
        invs    = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.position !== 4'hF) strobes++;
            if (bus.invalid !== 1'b0)  invs++;
        end
    endtask

    function automatic bit win(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit         found;
        logic [3:0] pos;
        logic       pl;
        int         s, iv, s2, iv2, lat;
        logic [3:0] moves [5];
        logic [8:0] p1, p2;
        logic [4:0] seq;

        moves = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
        bus.btn_next    = 1'b0;
        bus.btn_confirm = 1'b0;
        bus.occupied    = '0;
        bus.game_over   = 1'b0;
        reset = 1'b1;
        tick(3);
        check("rst_position", 32'(bus.position), 15);
        check("rst_player",   32'(bus.player),   0);
        check("rst_cursor",   32'(bus.cursor),   0);
        check("rst_invalid",  32'(bus.invalid),  0);
        check("rst_busy",     32'(bus.busy),     0);
        reset = 1'b0;
        tick(1);

        // First move on cell 0, acknowledged by the core.
        bus.btn_confirm = 1'b1;
        wait_strobe(20, found, pos, pl);
        check("m1_strobe", 32'(found), 1);
        check("m1_pos",    32'(pos),   0);
        check("m1_player", 32'(pl),    0);
        tick(1);
        check("m1_idle_after", 32'(bus.position), 15);
        check("m1_busy_wait",  32'(bus.busy),     1);
        bus.occupied = 9'h001;
        tick(1);
        check("m1_player_toggled", 32'(bus.player), 1);
        check("m1_busy_fell",      32'(bus.busy),   0);
        bus.btn_confirm = 1'b0;
        watch(14, s, iv);
        check("m1_single_strobe", 32'(s),  0);
        check("m1_no_invalid",    32'(iv), 0);

        // Cursor search over occupied cells, including the no-free-cell case.
        bus.occupied = 9'h00E;
        press_next();
        check("next_skip_to_4", 32'(bus.cursor), 4);
        bus.occupied = 9'h0FF;
        press_next();
        check("next_to_8", 32'(bus.cursor), 8);
        press_next();
        check("next_stays_8", 32'(bus.cursor), 8);

        // A two-cycle glitch is shorter than the debounce window.
        bus.btn_confirm = 1'b1;
        tick(2);
        bus.btn_confirm = 1'b0;
        watch(12, s, iv);
        check("glitch_no_strobe",  32'(s),  0);
        check("glitch_no_invalid", 32'(iv), 0);

        // Confirm on an occupied cell.
        bus.occupied = 9'h1FF;
        bus.btn_confirm = 1'b1;
        watch(10, s, iv);
        bus.btn_confirm = 1'b0;
        watch(10, s2, iv2);
        check("occ_no_strobe",    32'(s + s2),   0);
        check("occ_invalid_once", 32'(iv + iv2), 1);
        check("occ_player_same",  32'(bus.player), 1);
        check("occ_cursor_same",  32'(bus.cursor), 8);
        check("occ_not_busy",     32'(bus.busy),   0);

        // Commit that the core never acknowledges.
        bus.occupied = 9'h0FF;
        bus.btn_confirm = 1'b1;
        wait_strobe(20, found, pos, pl);
        check("to_strobe", 32'(found), 1);
        check("to_pos",    32'(pos),   8);
        check("to_player", 32'(pl),    1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.invalid === 1'b1) lat = k;
        end
        check("to_latency", 32'(lat), 8);
        tick(1);
        check("to_invalid_one_cycle", 32'(bus.invalid), 0);
        check("to_player_same",       32'(bus.player),  1);
        check("to_not_busy",          32'(bus.busy),    0);
        bus.btn_confirm = 1'b0;
        tick(10);

        // game_over while waiting for the acknowledge locks the controller.
        bus.btn_confirm = 1'b1;
        wait_strobe(20, found, pos, pl);
        check("lk_strobe", 32'(found), 1);
        tick(1);
        check("lk_busy_wait", 32'(bus.busy), 1);
        bus.game_over = 1'b1;
        tick(1);
        check("lk_busy_low",  32'(bus.busy),     0);
        check("lk_pos_idle",  32'(bus.position), 15);
        bus.game_over   = 1'b0;
        bus.btn_confirm = 1'b0;
        tick(10);
        bus.occupied = 9'h000;
        bus.btn_confirm = 1'b1;
        watch(10, s, iv);
        bus.btn_confirm = 1'b0;
        watch(10, s2, iv2);
        check("lk_no_strobe",  32'(s + s2),   0);
        check("lk_no_invalid", 32'(iv + iv2), 0);
        press_next();
        check("lk_cursor_frozen", 32'(bus.cursor), 8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rr_cursor",   32'(bus.cursor),   0);
        check("rr_player",   32'(bus.player),   0);
        check("rr_position", 32'(bus.position), 15);

        // Short game: player 1 takes the top row.
        bus.occupied = '0;
        p1  = '0;
        p2  = '0;
        seq = '0;
        for (int m = 0; m < 5; m++) begin
            for (int n = 0; n < 10 && bus.cursor !== moves[m]; n++) press_next();
            check("game_nav", 32'(bus.cursor), 32'(moves[m]));
            bus.btn_confirm = 1'b1;
            wait_strobe(20, found, pos, pl);
            check("game_strobe", 32'(found), 1);
            check("game_pos",    32'(pos),   32'(moves[m]));
            seq[m] = pl;
            tick(1);
            bus.occupied[moves[m]] = 1'b1;
            if (pl == 1'b0) p1[moves[m]] = 1'b1;
            else            p2[moves[m]] = 1'b1;
            bus.game_over = win(p1) | win(p2);
            tick(1);
            bus.btn_confirm = 1'b0;
            tick(10);
        end
        check("game_player_seq", 32'(seq),     32'(5'b01010));
        check("game_win1",       32'(win(p1)), 1);
        check("game_locked_busy", 32'(bus.busy), 0);
        bus.occupied = 9'h0FF;
        bus.btn_confirm = 1'b1;
        watch(12, s, iv);
        bus.btn_confirm = 1'b0;
        check("game_locked_no_strobe", 32'(s), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
